// File: rtl/dt_result_scan.sv
`default_nettype none
// ============================================================================
// Module   : dt_result_scan
// Brief    : Sequential scan of the finished distance-transform result map.
//            Reads every pixel once through the res read port and reports the
//            maximum distance, the lowest address holding it, the number of
//            object (nonzero) pixels and the sum of all distances.
// Revision : 1.0 - initial release
// ============================================================================
module dt_result_scan #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     res_rd,
  output logic [ADDR_W-1:0]        res_addr,
  input  logic [DATA_W-1:0]        res_di,
  output logic                     busy,
  output logic                     stat_valid,
  output logic [DATA_W-1:0]        max_val,
  output logic [ADDR_W-1:0]        max_addr,
  output logic [ADDR_W:0]          obj_cnt,
  output logic [DATA_W+ADDR_W-1:0] dist_sum
);

  localparam int                c_n    = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(c_n - 1);
  localparam logic [ADDR_W:0]   c_one  = (ADDR_W + 1)'(1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_read  = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  logic [1:0]              r_state;
  logic                    r_rd;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_busy;
  logic                    r_stat_valid;
  logic                    r_cap_vld;
  logic [ADDR_W-1:0]       r_cap_addr;
  logic [DATA_W-1:0]       r_max_val;
  logic [ADDR_W-1:0]       r_max_addr;
  logic [ADDR_W:0]         r_obj_cnt;
  logic [DATA_W+ADDR_W-1:0] r_dist_sum;
  logic                    w_launch;

  // A scan may only be launched from IDLE or DONE; start is ignored while busy.
  assign w_launch = start && ((r_state == c_st_idle) || (r_state == c_st_done));

  // Scan sequencer: issues addresses 0..N-1 back to back, then drains the last read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_rd         <= 1'b0;
      r_addr       <= '0;
      r_busy       <= 1'b0;
      r_stat_valid <= 1'b0;
    end else begin
      case (r_state)
        c_st_read: begin
          if (r_addr == c_last) begin
            // Last address issued; address returns to 0 with the strobe low.
            r_state <= c_st_drain;
            r_rd    <= 1'b0;
            r_addr  <= '0;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        c_st_drain: begin
          r_state      <= c_st_done;
          r_busy       <= 1'b0;
          r_stat_valid <= 1'b1;
        end
        default: begin
          if (w_launch) begin
            r_state      <= c_st_read;
            r_rd         <= 1'b1;
            r_addr       <= '0;
            r_busy       <= 1'b1;
            r_stat_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Read data returns one cycle late, so remember which address it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_vld  <= 1'b0;
      r_cap_addr <= '0;
    end else begin
      r_cap_vld  <= r_rd;
      r_cap_addr <= r_addr;
    end
  end

  // Statistics accumulate on returned data and are cleared when a scan launches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max_val  <= '0;
      r_max_addr <= '0;
      r_obj_cnt  <= '0;
      r_dist_sum <= '0;
    end else if (w_launch) begin
      r_max_val  <= '0;
      r_max_addr <= '0;
      r_obj_cnt  <= '0;
      r_dist_sum <= '0;
    end else if (r_cap_vld) begin
      // Strict compare keeps the earliest (lowest) address on ties.
      if (res_di > r_max_val) begin
        r_max_val  <= res_di;
        r_max_addr <= r_cap_addr;
      end
      if (res_di != '0) begin
        r_obj_cnt <= r_obj_cnt + c_one;
      end
      r_dist_sum <= r_dist_sum + {{ADDR_W{1'b0}}, res_di};
    end
  end

  assign res_rd     = r_rd;
  assign res_addr   = r_addr;
  assign busy       = r_busy;
  assign stat_valid = r_stat_valid;
  assign max_val    = r_max_val;
  assign max_addr   = r_max_addr;
  assign obj_cnt    = r_obj_cnt;
  assign dist_sum   = r_dist_sum;

endmodule
`default_nettype wire

// File: tb/tb_dt_result_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_dt_result_scan
// Brief    : Self-checking bench for dt_result_scan on a 24x20 map (N=480,
//            non-power-of-two) with a behavioural memory and reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dt_result_scan;

  localparam int IMG_W  = 24;
  localparam int IMG_H  = 20;
  localparam int N      = IMG_W * IMG_H;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic                     res_rd;
  logic [ADDR_W-1:0]        res_addr;
  logic [DATA_W-1:0]        res_di = '0;
  logic                     busy;
  logic                     stat_valid;
  logic [DATA_W-1:0]        max_val;
  logic [ADDR_W-1:0]        max_addr;
  logic [ADDR_W:0]          obj_cnt;
  logic [DATA_W+ADDR_W-1:0] dist_sum;

  logic [DATA_W-1:0] mem [N];

  int tests = 0;
  int fails = 0;
  int scan_id = 0;
  int mon_id = 0;
  int rd_cnt = 0;
  int rd_bad = 0;
  int edges;

  typedef struct {
    string nm;
    int    kind;
    int    emax;
    int    eaddr;
    int    ecnt;
    int    esum;
  } vec_t;
  vec_t vt [4];

  dt_result_scan #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
    .busy(busy), .stat_valid(stat_valid),
    .max_val(max_val), .max_addr(max_addr), .obj_cnt(obj_cnt), .dist_sum(dist_sum)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; junk on idle cycles must never be accumulated.
  always @(posedge clk) begin
    if (res_rd && (int'(res_addr) < N)) res_di <= mem[res_addr];
    else                                res_di <= DATA_W'($urandom);
  end

  // Address monitor: reads must be 0,1,2,... with no gaps; idle address is 0.
  always @(negedge clk) begin
    if (mon_id != scan_id) begin
      mon_id = scan_id;
      rd_cnt = 0;
      rd_bad = 0;
    end
    if (res_rd) begin
      if ((int'(res_addr) != rd_cnt) || (int'(res_addr) >= N)) rd_bad++;
      rd_cnt++;
    end else if (res_addr != '0) begin
      rd_bad++;
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference: one pass over the map with plain arithmetic.
  task automatic model(output int mx, output int ma, output int cnt, output int sum);
    mx = 0; ma = 0; cnt = 0; sum = 0;
    for (int i = 0; i < N; i++) begin
      if (int'(mem[i]) > mx) begin mx = int'(mem[i]); ma = i; end
      if (mem[i] != 0) cnt++;
      sum += int'(mem[i]);
    end
  endtask

  task automatic fill_map(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       mem[i] = 8'd0;
        3:       mem[i] = 8'd255;
        4:       mem[i] = (($urandom % 4) == 0) ? 8'd0 : DATA_W'($urandom);
        default: mem[i] = 8'd0;
      endcase
    end
    if (kind == 1) mem[300] = 8'd5;
    if (kind == 2) begin mem[10] = 8'd7; mem[400] = 8'd7; mem[20] = 8'd3; end
  endtask

  task automatic cmp_stats(input string tag, input int mx, input int ma, input int cnt, input int sum);
    check({tag, ".max_val"},  64'(max_val),  64'(mx));
    check({tag, ".max_addr"}, 64'(max_addr), 64'(ma));
    check({tag, ".obj_cnt"},  64'(obj_cnt),  64'(cnt));
    check({tag, ".dist_sum"}, 64'(dist_sum), 64'(sum));
  endtask

  // Launch one scan from IDLE/DONE and wait for stat_valid (bounded).
  // With repulse set, start is pulsed again mid-scan and must be ignored.
  task automatic do_scan(input string tag, input bit repulse);
    scan_id++;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    edges = 1;
    #1 start = 1'b0;
    check({tag, ".busy_on"}, 64'({busy, stat_valid}), 64'(2'b10));
    while (!stat_valid && edges < N + 20) begin
      @(posedge clk);
      edges++;
      #1;
      if (repulse) start = (edges == 50);
    end
    start = 1'b0;
    check({tag, ".latency"}, 64'(edges), 64'(N + 2));
    check({tag, ".reads"},   64'(rd_cnt), 64'(N));
    check({tag, ".rd_seq"},  64'(rd_bad), 64'(0));
    check({tag, ".busy_off"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int mx, ma, cnt, sum;
    vt[0] = '{"zero",   0, 0,   0,   0,   0};
    vt[1] = '{"single", 1, 5,   300, 1,   5};
    vt[2] = '{"tie",    2, 7,   10,  3,   17};
    vt[3] = '{"all255", 3, 255, 0,   N,   255 * N};

    fill_map(4);
    repeat (3) @(posedge clk);
    #1;
    check("reset.outputs", 64'({res_rd, res_addr, busy, stat_valid, max_val, max_addr, obj_cnt, dist_sum}), 64'(0));
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle.no_start", 64'({busy, stat_valid, res_rd}), 64'(0));

    // Directed map patterns with hand-computed results.
    for (int v = 0; v < 4; v++) begin
      fill_map(vt[v].kind);
      do_scan(vt[v].nm, 1'b0);
      cmp_stats(vt[v].nm, vt[v].emax, vt[v].eaddr, vt[v].ecnt, vt[v].esum);
    end

    // Randomized maps against the reference; stats must also hold in DONE.
    for (int r = 0; r < 3; r++) begin
      fill_map(4);
      if (r == 1) begin mem[N-1] = 8'd255; mem[N-2] = 8'd0; end
      model(mx, ma, cnt, sum);
      do_scan($sformatf("rand%0d", r), 1'b0);
      repeat (3) @(negedge clk);
      cmp_stats($sformatf("rand%0d", r), mx, ma, cnt, sum);
      check($sformatf("rand%0d.held_valid", r), 64'(stat_valid), 64'(1));
    end

    // start during READ is ignored; then a restart from DONE repeats results.
    fill_map(4);
    model(mx, ma, cnt, sum);
    do_scan("repulse", 1'b1);
    cmp_stats("repulse", mx, ma, cnt, sum);
    do_scan("redo", 1'b0);
    cmp_stats("redo", mx, ma, cnt, sum);

    // start held high: one DONE cycle, then an automatic restart.
    scan_id++;
    @(negedge clk) start = 1'b1;
    edges = 0;
    while (!stat_valid && edges < N + 20) begin @(posedge clk); edges++; #1; end
    cmp_stats("held1", mx, ma, cnt, sum);
    @(posedge clk);
    #1;
    check("held.restart", 64'({stat_valid, busy, res_rd}), 64'(3'b011));
    scan_id++;
    start = 1'b0;
    edges = 0;
    while (!stat_valid && edges < N + 20) begin @(posedge clk); edges++; #1; end
    check("held2.reads", 64'(rd_cnt), 64'(N));
    cmp_stats("held2", mx, ma, cnt, sum);

    // Asynchronous reset mid-scan wipes everything at once.
    scan_id++;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    edges = 0;
    while (res_addr != ADDR_W'(200) && edges < N + 20) begin @(negedge clk); edges++; end
    check("rst.reached_200", 64'(res_addr), 64'(200));
    #2 rst = 1'b1;
    #1;
    check("rst.async_zero", 64'({res_rd, res_addr, busy, stat_valid, max_val, max_addr, obj_cnt, dist_sum}), 64'(0));
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("rst.idle", 64'({busy, stat_valid, res_rd}), 64'(0));
    do_scan("after_rst", 1'b0);
    cmp_stats("after_rst", mx, ma, cnt, sum);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dt_result_scan.md
Name: dt_result_scan

Overview:
- Post-processing stage directly downstream of the distance-transform engine.
- After the DT engine asserts done, this block scans the finished result map sequentially through the res memory read port.
- It produces summary statistics for the host or next stage: maximum distance, address of the first maximum, count of object (nonzero) pixels, and the distance sum.
- It owns the res read port only while busy; the top-level mux hands it the port after DT completes.

Parameters:
- IMG_W, 128, image width in pixels.
- IMG_H, 128, image height in pixels.
- ADDR_W, 14, res address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- DATA_W, 8, distance value width.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE or DONE.
- res_rd  output  1  read strobe to res memory.
- res_addr  output  ADDR_W  read address.
- res_di  input  DATA_W  read data, valid exactly one cycle after the address/strobe cycle.
- busy  output  1  high in READ and DRAIN.
- stat_valid  output  1  high in DONE; statistics are stable while high.
- max_val  output  DATA_W  largest distance found.
- max_addr  output  ADDR_W  lowest address holding max_val.
- obj_cnt  output  ADDR_W+1  number of nonzero pixels.
- dist_sum  output  DATA_W+ADDR_W  sum of all distances; no overflow is possible.

Behaviour:
- Reset (rst=1, async):
  - state=IDLE.
  - res_rd=0, res_addr=0, busy=0, stat_valid=0.
  - max_val=0, max_addr=0, obj_cnt=0, dist_sum=0.
  - Reset mid-scan aborts immediately and returns to these values; no partial statistics survive.
- States IDLE, READ, DRAIN, DONE. All outputs are registered.
- IDLE:
  - start=1 -> READ.
  - Clear all statistics and the address counter on the same edge.
- READ:
  - res_rd=1 and res_addr=k, with k counting 0..N-1 (N=IMG_W*IMG_H), one address per cycle, no bubbles.
  - When k=N-1 is issued -> DRAIN.
- Data capture:
  - On every cycle following a res_rd=1 cycle, res_di belongs to address k-1 (tracked by a one-cycle-delayed address register plus valid flag).
  - If res_di > max_val (strict): max_val<=res_di, max_addr<=captured address. Ties keep the earlier (lower) address.
  - If res_di != 0: obj_cnt increments.
  - dist_sum += res_di, zero-extended.
- DRAIN:
  - res_rd=0.
  - Captures the data for address N-1.
  - -> DONE.
- DONE:
  - stat_valid=1; statistics are held.
  - start=1 -> READ, with statistics cleared on that edge; stat_valid drops on that edge.
- Latency:
  - start sampled at edge t.
  - First res_rd at cycle t+1.
  - Last address issued at cycle t+N.
  - stat_valid rises at the edge ending cycle t+N+1 (DRAIN), i.e. N+2 edges after start.
- start during READ or DRAIN is ignored; no queuing.
- start held high continuously restarts on each DONE entry after one DONE cycle.
- Address counter never wraps past N-1. For non-power-of-two N, unused addresses are never read.
- res_addr returns to 0 when res_rd=0.

Test Plan:
- All-zero map, start pulse -> N=16384 consecutive reads 0..16383; stat_valid rises 16386 edges after start; max_val=0, max_addr=0, obj_cnt=0, dist_sum=0.
- Single pixel value 5 at addr 300, rest 0 -> max_val=5, max_addr=300, obj_cnt=1, dist_sum=5.
- Tie: value 7 at addr 10 and addr 9000, value 3 at addr 20 -> max_val=7, max_addr=10, obj_cnt=3, dist_sum=17.
- All pixels 255 -> max_val=255, max_addr=0, obj_cnt=16384, dist_sum=4177920.
- start re-pulsed at scan cycle 50 (busy=1) -> ignored; address sequence is uninterrupted and results equal a single scan. Then start in DONE -> stat_valid drops next edge and a fresh scan reproduces identical results.
- rst asserted at read address 8000 -> all outputs 0 asynchronously, state IDLE; a subsequent start yields a full correct scan from addr 0.
